// File: rtl/snake_pkg.sv
// Shared snake-game constants: playfield geometry, coordinate widths and
// the food spawn FSM state encoding.
package snake_pkg;

  localparam int unsigned SCREEN_W = 240;
  localparam int unsigned SCREEN_H = 320;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    QUERY  = 2'd2
  } spawn_state_t;

endpackage

// File: rtl/food_cell_align.sv
// Snaps a pixel coordinate down to its cell origin and reports whether the
// cell lies inside the playfield.
module food_cell_align
  import snake_pkg::*;
#(
  parameter int unsigned CELL_LOG2 = 4
) (
  input  logic [X_W-1:0] raw_x,
  input  logic [Y_W-1:0] raw_y,
  output logic [X_W-1:0] cell_x,
  output logic [Y_W-1:0] cell_y,
  output logic           in_range
);

  // Clearing the low CELL_LOG2 bits is the grid snap; no division needed.
  localparam logic [X_W-1:0] X_MASK = {X_W{1'b1}} << CELL_LOG2;
  localparam logic [Y_W-1:0] Y_MASK = {Y_W{1'b1}} << CELL_LOG2;

  assign cell_x   = raw_x & X_MASK;
  assign cell_y   = raw_y & Y_MASK;
  assign in_range = (cell_x < X_W'(SCREEN_W)) && (cell_y < Y_W'(SCREEN_H));

endmodule

// File: rtl/food_spawn_controller.sv
// Food placement sequencer: samples random cells, checks them against the
// snake body tracker, and owns the registered food position.
module food_spawn_controller
  import snake_pkg::*;
#(
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           spawn_req,
  input  logic [X_W-1:0] rand_x,
  input  logic [Y_W-1:0] rand_y,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           spawn_done,
  output logic           spawn_fail,
  output logic           busy
);

  spawn_state_t   state;
  logic           pending;
  logic [7:0]     try_cnt;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_ok;
  logic           last_try;

  food_cell_align #(
    .CELL_LOG2(CELL_LOG2)
  ) u_align (
    .raw_x   (rand_x),
    .raw_y   (rand_y),
    .cell_x  (cand_x),
    .cell_y  (cand_y),
    .in_range(cand_ok)
  );

  assign last_try = (try_cnt == 8'(MAX_TRIES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      try_cnt    <= '0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      busy       <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn_req || pending) begin
            food_valid <= 1'b0;
            pending    <= 1'b0;
            try_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (spawn_req) pending <= 1'b1;
          if (cand_ok) begin
            occ_x   <= cand_x;
            occ_y   <= cand_y;
            occ_req <= 1'b1;
            state   <= QUERY;
          end else if (last_try) begin
            // Off-field sample counts against the budget exactly like a hit.
            spawn_fail <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            try_cnt <= try_cnt + 8'd1;
          end
        end
        QUERY: begin
          if (spawn_req) pending <= 1'b1;
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit) begin
              food_x     <= occ_x;
              food_y     <= occ_y;
              food_valid <= 1'b1;
              spawn_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if (last_try) begin
              spawn_fail <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              try_cnt <= try_cnt + 8'd1;
              state   <= SAMPLE;
            end
          end
        end
        default: begin
          occ_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawn_controller.sv
// Directed bench for food_spawn_controller: single spawn, retries, budget
// exhaustion, pending requests, stalled acks, off-field samples and reset abort.
module tb_food_spawn_controller;

  logic       clock;
  logic       reset;
  logic       spawn_req;
  logic [7:0] rand_x;
  logic [8:0] rand_y;
  logic       occ_req;
  logic [7:0] occ_x;
  logic [8:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [7:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       spawn_done;
  logic       spawn_fail;
  logic       busy;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned hs_cnt;
  bit          ok;

  food_spawn_controller #(
    .CELL_LOG2(4),
    .MAX_TRIES(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .spawn_req (spawn_req),
    .rand_x    (rand_x),
    .rand_y    (rand_y),
    .occ_req   (occ_req),
    .occ_x     (occ_x),
    .occ_y     (occ_y),
    .occ_ack   (occ_ack),
    .occ_hit   (occ_hit),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .spawn_done(spawn_done),
    .spawn_fail(spawn_fail),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_spawn();
    spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (occ_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake(input logic hit);
    bit seen;
    wait_req(seen);
    check("req_seen", 32'(seen), 32'd1);
    if (seen) begin
      occ_ack = 1'b1;
      occ_hit = hit;
      @(negedge clock);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      hs_cnt++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hs_cnt      = 0;
    reset       = 1'b1;
    spawn_req   = 1'b0;
    occ_ack     = 1'b0;
    occ_hit     = 1'b0;
    rand_x      = 8'd37;
    rand_y      = 9'd150;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_occ_req", 32'(occ_req), 32'd0);
    check("rst_occ_x", 32'(occ_x), 32'd0);
    check("rst_occ_y", 32'(occ_y), 32'd0);
    check("rst_food_x", 32'(food_x), 32'd0);
    check("rst_food_y", 32'(food_y), 32'd0);
    check("rst_food_valid", 32'(food_valid), 32'd0);
    check("rst_done", 32'(spawn_done), 32'd0);
    check("rst_fail", 32'(spawn_fail), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single spawn, minimum latency: 37 -> 32, 150 -> 144
    pulse_spawn();
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_req_early", 32'(occ_req), 32'd0);
    @(negedge clock);
    check("s1_occ_req", 32'(occ_req), 32'd1);
    check("s1_occ_x", 32'(occ_x), 32'd32);
    check("s1_occ_y", 32'(occ_y), 32'd144);
    check("s1_fv_pre", 32'(food_valid), 32'd0);
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    @(negedge clock);
    occ_ack = 1'b0;
    check("s1_done", 32'(spawn_done), 32'd1);
    check("s1_food_valid", 32'(food_valid), 32'd1);
    check("s1_food_x", 32'(food_x), 32'd32);
    check("s1_food_y", 32'(food_y), 32'd144);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_req_end", 32'(occ_req), 32'd0);
    @(negedge clock);
    check("s1_done_pulse", 32'(spawn_done), 32'd0);
    check("s1_fv_hold", 32'(food_valid), 32'd1);

    // Retry: three hits, then a free cell
    hs_cnt = 0;
    pulse_spawn();
    check("rt_fv_cleared", 32'(food_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      handshake(1'b1);
      check("rt_no_fail", 32'(spawn_fail), 32'd0);
      check("rt_no_done", 32'(spawn_done), 32'd0);
      check("rt_fv_low", 32'(food_valid), 32'd0);
    end
    handshake(1'b0);
    check("rt_done", 32'(spawn_done), 32'd1);
    check("rt_fv", 32'(food_valid), 32'd1);
    check("rt_handshakes", hs_cnt, 32'd4);

    // Exhaustion: all 16 queries hit
    hs_cnt = 0;
    pulse_spawn();
    for (int i = 0; i < 15; i++) handshake(1'b1);
    check("ex_no_early_fail", 32'(spawn_fail), 32'd0);
    check("ex_busy_mid", 32'(busy), 32'd1);
    handshake(1'b1);
    check("ex_fail", 32'(spawn_fail), 32'd1);
    check("ex_done", 32'(spawn_done), 32'd0);
    check("ex_fv", 32'(food_valid), 32'd0);
    check("ex_busy", 32'(busy), 32'd0);
    check("ex_handshakes", hs_cnt, 32'd16);
    @(negedge clock);
    check("ex_fail_pulse", 32'(spawn_fail), 32'd0);

    // Pending: two requests in QUERY plus one on the completion edge
    pulse_spawn();
    wait_req(ok);
    check("pd_req_seen", 32'(ok), 32'd1);
    spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    @(negedge clock);
    spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    check("pd_still_query", 32'(occ_req), 32'd1);
    spawn_req = 1'b1;
    occ_ack   = 1'b1;
    occ_hit   = 1'b0;
    @(negedge clock);
    spawn_req = 1'b0;
    occ_ack   = 1'b0;
    check("pd_done1", 32'(spawn_done), 32'd1);
    check("pd_idle", 32'(busy), 32'd0);
    @(negedge clock);
    check("pd_resample", 32'(busy), 32'd1);
    check("pd_fv_cleared", 32'(food_valid), 32'd0);
    check("pd_req_low", 32'(occ_req), 32'd0);
    handshake(1'b0);
    check("pd_done2", 32'(spawn_done), 32'd1);
    repeat (4) @(negedge clock);
    check("pd_no_third", 32'(busy), 32'd0);
    check("pd_fv", 32'(food_valid), 32'd1);

    // Stalled ack: candidate held while random inputs keep moving
    rand_x = 8'd37;
    rand_y = 9'd150;
    pulse_spawn();
    wait_req(ok);
    check("st_req_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      rand_x = 8'($urandom_range(0, 239));
      rand_y = 9'($urandom_range(0, 319));
      @(negedge clock);
      check("st_occ_req", 32'(occ_req), 32'd1);
      check("st_occ_x", 32'(occ_x), 32'd32);
      check("st_occ_y", 32'(occ_y), 32'd144);
    end
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    @(negedge clock);
    occ_ack = 1'b0;
    check("st_done", 32'(spawn_done), 32'd1);
    check("st_food_x", 32'(food_x), 32'd32);
    check("st_food_y", 32'(food_y), 32'd144);

    // Off-field sample rejected, then field-edge cell 239/319 -> 224/304
    rand_x = 8'd250;
    rand_y = 9'd150;
    pulse_spawn();
    @(negedge clock);
    check("or_no_query", 32'(occ_req), 32'd0);
    check("or_busy", 32'(busy), 32'd1);
    rand_x = 8'd239;
    rand_y = 9'd319;
    @(negedge clock);
    check("or_req", 32'(occ_req), 32'd1);
    check("or_occ_x", 32'(occ_x), 32'd224);
    check("or_occ_y", 32'(occ_y), 32'd304);
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    @(negedge clock);
    occ_ack = 1'b0;
    check("or_done", 32'(spawn_done), 32'd1);
    check("or_food_x", 32'(food_x), 32'd224);
    check("or_food_y", 32'(food_y), 32'd304);

    // Off-field exhaustion at x = 240: 16 rejections then fail, no query
    rand_x = 8'd240;
    pulse_spawn();
    repeat (15) @(negedge clock);
    check("of_no_early_fail", 32'(spawn_fail), 32'd0);
    check("of_busy_mid", 32'(busy), 32'd1);
    @(negedge clock);
    check("of_fail", 32'(spawn_fail), 32'd1);
    check("of_busy", 32'(busy), 32'd0);
    check("of_no_query", 32'(occ_req), 32'd0);
    check("of_fv", 32'(food_valid), 32'd0);

    // Reset mid-QUERY with a pending request
    rand_x = 8'd37;
    rand_y = 9'd150;
    pulse_spawn();
    wait_req(ok);
    check("rq_req_seen", 32'(ok), 32'd1);
    spawn_req = 1'b1;
    @(negedge clock);
    spawn_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rq_occ_req", 32'(occ_req), 32'd0);
    check("rq_busy", 32'(busy), 32'd0);
    check("rq_fv", 32'(food_valid), 32'd0);
    check("rq_done", 32'(spawn_done), 32'd0);
    check("rq_fail", 32'(spawn_fail), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rq_pending_cleared", 32'(busy), 32'd0);
    check("rq_no_pulse", 32'(spawn_done), 32'd0);
    pulse_spawn();
    handshake(1'b0);
    check("rq_after_done", 32'(spawn_done), 32'd1);
    check("rq_after_food_x", 32'(food_x), 32'd32);
    check("rq_after_food_y", 32'(food_y), 32'd144);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/food_spawn_controller.md
# food_spawn_controller

Sequences food placement for the snake game on the 240x320 playfield. On a spawn request it samples the free-running random X/Y generator, snaps the sample to the cell grid, and asks the snake-body tracker whether that cell is occupied. It retries with fresh samples until it finds a free cell or exhausts its try budget. It sits between the random generator, the snake body store and the game FSM, and it owns the registered food position read by the renderer and collision logic.

## Interface
- CELL_LOG2, 4: log2 of cell edge in pixels (16 px cells → 15x20 grid)
- MAX_TRIES, 16: candidate attempts per spawn before failure (2..255)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- spawn_req  in  1  one-cycle pulse: food eaten / game start
- rand_x  in  8  random X sample, 0..239, changes every cycle
- rand_y  in  9  random Y sample, 0..319, changes every cycle
- occ_req  out  1  occupancy query valid, held until occ_ack
- occ_x  out  8  queried cell X (pixels, aligned)
- occ_y  out  9  queried cell Y (pixels, aligned)
- occ_ack  in  1  query answered this cycle
- occ_hit  in  1  valid with occ_ack: 1 = cell occupied by snake
- food_x  out  8  current food X (aligned)
- food_y  out  9  current food Y (aligned)
- food_valid  out  1  food present on board
- spawn_done  out  1  one-cycle pulse: new food placed
- spawn_fail  out  1  one-cycle pulse: MAX_TRIES exhausted
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SAMPLE, QUERY.
- IDLE: on spawn_req, or on pending=1, clear food_valid and pending, set try_cnt=0, go to SAMPLE.
- SAMPLE: capture cand_x={rand_x[7:CELL_LOG2],0s}, cand_y={rand_y[8:CELL_LOG2],0s}.
  - If cand_x>=240 or cand_y>=320, treat the sample as a hit, with no query.
  - Otherwise go to QUERY.
- QUERY: drive occ_req=1, occ_x/occ_y=cand, stable until an edge with occ_ack=1.
  - ack, hit=0: load food_x/y=cand, set food_valid=1, pulse spawn_done, go to IDLE.
  - ack, hit=1: if try_cnt==MAX_TRIES-1, pulse spawn_fail, keep food_valid=0, go to IDLE. Otherwise increment try_cnt and go to SAMPLE.
- The out-of-range rejection in SAMPLE follows the same try_cnt/fail rule as a hit.
- spawn_req while busy sets pending. Pending holds one request only; further requests coalesce into it. Pending is served on return to IDLE.
- A spawn_req in the same cycle as completion is captured into pending and is not lost.
- occ_ack outside QUERY is ignored.
- try_cnt is 8 bits wide. Candidate arithmetic is bit-select only, with no division.

## Timing
- Reset values: state IDLE; occ_req, food_valid, spawn_done, spawn_fail, busy, pending = 0; food_x, food_y, occ_x, occ_y, try_cnt = 0.
- All outputs are registered.
- spawn_req sampled at edge N: SAMPLE during cycle N→N+1; occ_req is high after edge N+1.
- Minimum latency: occ_ack high at edge N+2 gives food_valid=1 and spawn_done=1 after edge N+2, i.e. 2 cycles.
- Each retry costs one SAMPLE cycle plus the query wait.
- Pending service: IDLE lasts exactly one cycle before SAMPLE.
- Reset mid-operation aborts immediately: occ_req drops, no done/fail pulse is produced, and pending is cleared.

## Structure
- Shared snake_pkg holds: SCREEN_W=240, SCREEN_H=320, X_W=8, Y_W=9, and the state encoding for this FSM.
- One natural combinational sub-module, food_cell_align: grid snap plus in-range check, reused by the movement logic.
- Everything else lives in one module: FSM, try counter, pending flag, output registers.

## Test plan
- Single spawn: reset, then spawn_req with rand_x=37, rand_y=150, occ_ack at the first query edge with hit=0 → occ_x=32, occ_y=144; food_x=32, food_y=144, food_valid=1 and spawn_done pulse 2 cycles after the request.
- Retry: hit=1 for the first 3 queries, then hit=0 → exactly 4 occ_req handshakes, one spawn_done, try_cnt never reaches the fail threshold, food_valid=0 until done.
- Exhaustion: MAX_TRIES=16, every query hit=1 → 16 handshakes, then a single spawn_fail pulse, food_valid=0, busy=0.
- Pending: spawn_req twice while in QUERY, plus once on the completion edge → exactly one extra spawn cycle follows, ending in a second spawn_done.
- Stalled ack: occ_ack withheld 10 cycles → occ_req, occ_x and occ_y stable throughout; rand_x/rand_y changes have no effect.
- Reset mid-QUERY: assert reset → occ_req=0 and busy=0 immediately, food_valid=0, no pulses; the next spawn_req proceeds normally.
